console_tx_buffer: RTL and testbench

- Buffered bridge between the Brainfuck core's stdout strobe and uart_tx.
- Replaces the single-character edge-detect/start logic, which halts the core for every character. The core now stalls only when the buffer is nearly full.
- Adds a parametrised FIFO depth, a configurable cell width, an optional LF->CRLF translation mode and sticky overflow reporting.
- Sits in the top level between proc (stdout/stdout_en/en) and uart_tx (data/start/ready), in the clk domain.

---
 rtl/console_tx_buffer_pkg.sv | 18 +
 rtl/console_tx_buffer_sync_fifo.sv | 64 ++++++
 rtl/console_tx_buffer.sv | 138 +++++++++++++
 tb/tb_console_tx_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_tx_buffer_pkg.sv
// Shared definitions for the console transmit buffer: TX FSM states and ASCII/timing constants.
package console_tx_buffer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone,
    StCrWait
  } tx_state_e;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;

  // Cycles to wait in StWaitBusy for the UART to drop ready before moving on anyway.
  localparam int unsigned WaitBusyTimeout = 4;

endpackage

// File: rtl/console_tx_buffer_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter so full and empty are unambiguous.
module console_tx_buffer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic            pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [LvlW-1:0] level_o,
  output logic [LvlW-1:0] level_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign level_next_o = level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the level counter defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/console_tx_buffer.sv
// Buffered bridge from the core's stdout strobe to uart_tx, with stall, overflow and LF->CRLF.
module console_tx_buffer
  import console_tx_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          EDGE_MODE  = 1'b1,
  parameter bit          LF_TO_CRLF = 1'b0,
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  cpu_stall,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_ready,
  output logic [LvlW-1:0]       fifo_level,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  tx_state_e state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       cr_pending_q, cr_pending_d;
  logic [2:0] busy_cnt_q, busy_cnt_d;
  logic       wr_en_q;
  logic       overflow_q, overflow_d;
  logic       cpu_stall_q, cpu_stall_d;

  logic            push_accept, fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]      fifo_head;
  logic [LvlW-1:0] level_next;
  logic            unused_wr_data;

  assign unused_wr_data = ^wr_data[DATA_WIDTH-1:8];

  assign push_accept = EDGE_MODE ? (wr_en && !wr_en_q) : wr_en;
  // Full check uses the pre-edge level, so a same-cycle pop never rescues a push.
  assign drop      = push_accept && fifo_full;
  assign fifo_push = push_accept && !fifo_full;

  console_tx_buffer_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .push_i       (fifo_push),
    .data_i       (wr_data[7:0]),
    .pop_i        (fifo_pop),
    .data_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .level_o      (fifo_level),
    .level_next_o (level_next)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  // Stall one entry early so a write already in flight still has a slot.
  assign cpu_stall_d = (level_next >= LvlW'(FIFO_DEPTH - 1));

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    cr_pending_d = cr_pending_q;
    busy_cnt_d   = busy_cnt_q;
    fifo_pop     = 1'b0;
    tx_start     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && tx_ready) begin
          state_d = StStart;
          if (LF_TO_CRLF && (fifo_head == AsciiLf)) begin
            tx_data_d    = AsciiCr;
            cr_pending_d = 1'b1;
          end else begin
            tx_data_d = fifo_head;
            fifo_pop  = 1'b1;
          end
        end
      end
      StStart: begin
        tx_start   = 1'b1;
        busy_cnt_d = '0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_ready || (busy_cnt_q == 3'(WaitBusyTimeout - 1))) begin
          state_d = StWaitDone;
        end else begin
          busy_cnt_d = busy_cnt_q + 3'd1;
        end
      end
      StWaitDone: begin
        if (tx_ready) state_d = cr_pending_q ? StCrWait : StIdle;
      end
      StCrWait: begin
        tx_data_d    = AsciiLf;
        fifo_pop     = 1'b1;
        cr_pending_d = 1'b0;
        state_d      = StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      tx_data_q    <= '0;
      cr_pending_q <= 1'b0;
      busy_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      overflow_q   <= 1'b0;
      cpu_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      cr_pending_q <= cr_pending_d;
      busy_cnt_q   <= busy_cnt_d;
      wr_en_q      <= wr_en;
      overflow_q   <= overflow_d;
      cpu_stall_q  <= cpu_stall_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;
  assign cpu_stall = cpu_stall_q;

endmodule

// File: tb/tb_console_tx_buffer.sv
// Scoreboard bench: one edge-mode/CRLF instance and one level-mode instance with UART models.
module tb_console_tx_buffer;

  localparam int unsigned Busy = 20;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Edge-mode instance with LF->CRLF enabled.
  logic [31:0] wr_data_e = '0;
  logic        wr_en_e = 1'b0, clr_e = 1'b0, hold_e = 1'b0;
  logic        cpu_stall_e, tx_start_e, ready_e, ovf_e;
  logic [7:0]  tx_data_e;
  logic [4:0]  lvl_e;
  int          busy_e;

  // Level-mode instance.
  logic [31:0] wr_data_l = '0;
  logic        wr_en_l = 1'b0, clr_l = 1'b0, hold_l = 1'b1;
  logic        cpu_stall_l, tx_start_l, ready_l, ovf_l;
  logic [7:0]  tx_data_l;
  logic [4:0]  lvl_l;
  int          busy_l;

  console_tx_buffer #(
    .DATA_WIDTH (32), .FIFO_DEPTH (16), .EDGE_MODE (1'b1), .LF_TO_CRLF (1'b1)
  ) dut_e (
    .clk (clk), .rstn (rstn), .wr_data (wr_data_e), .wr_en (wr_en_e),
    .cpu_stall (cpu_stall_e), .tx_data (tx_data_e), .tx_start (tx_start_e),
    .tx_ready (ready_e), .fifo_level (lvl_e), .overflow (ovf_e), .clr_overflow (clr_e)
  );

  console_tx_buffer #(
    .DATA_WIDTH (32), .FIFO_DEPTH (16), .EDGE_MODE (1'b0), .LF_TO_CRLF (1'b0)
  ) dut_l (
    .clk (clk), .rstn (rstn), .wr_data (wr_data_l), .wr_en (wr_en_l),
    .cpu_stall (cpu_stall_l), .tx_data (tx_data_l), .tx_start (tx_start_l),
    .tx_ready (ready_l), .fifo_level (lvl_l), .overflow (ovf_l), .clr_overflow (clr_l)
  );

  // UART models: busy for Busy cycles after each start pulse; hold forces ready low.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) busy_e <= 0;
    else if (tx_start_e) busy_e <= Busy;
    else if (busy_e != 0) busy_e <= busy_e - 1;
  end
  always @(posedge clk or negedge rstn) begin
    if (!rstn) busy_l <= 0;
    else if (tx_start_l) busy_l <= Busy;
    else if (busy_l != 0) busy_l <= busy_l - 1;
  end
  assign ready_e = (busy_e == 0) && !hold_e;
  assign ready_l = (busy_l == 0) && !hold_l;

  logic [7:0] q_e[$];
  logic [7:0] q_l[$];
  int   pulses_e = 0, pulses_l = 0;
  logic prev_e = 1'b0, prev_l = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every start pulse pops one expected byte.
  always @(negedge clk) begin
    if (rstn && tx_start_e) begin
      pulses_e <= pulses_e + 1;
      chk("start_single_e", {31'd0, prev_e}, 32'd0);
      if (q_e.size() == 0) chk("unexpected_start_e", {24'd0, tx_data_e}, 32'hFFFF_FFFF);
      else chk("tx_data_e", {24'd0, tx_data_e}, {24'd0, q_e.pop_front()});
    end
    prev_e <= tx_start_e;
  end
  always @(negedge clk) begin
    if (rstn && tx_start_l) begin
      pulses_l <= pulses_l + 1;
      chk("start_single_l", {31'd0, prev_l}, 32'd0);
      if (q_l.size() == 0) chk("unexpected_start_l", {24'd0, tx_data_l}, 32'hFFFF_FFFF);
      else chk("tx_data_l", {24'd0, tx_data_l}, {24'd0, q_l.pop_front()});
    end
    prev_l <= tx_start_l;
  end

  task automatic push_e(input logic [7:0] b);
    @(negedge clk);
    wr_en_e = 1'b1;
    wr_data_e = {24'hABCDEF, b};
    @(negedge clk);
    wr_en_e = 1'b0;
  endtask

  task automatic drain_e();
    int n = 0;
    while ((lvl_e != 0) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout_e", {27'd0, lvl_e}, 32'd0);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int n;
    bit saw_stall;
    int pulses_before;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start_e}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data_e}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall_e}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_e}, 32'd0);
    chk("rst_level", {27'd0, lvl_e}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Edge mode: wr_en held 5 cycles gives one push; start two cycles after the accepting edge.
    wr_en_e = 1'b1;
    wr_data_e = 32'h0000_0141;
    q_e.push_back(8'h41);
    @(negedge clk);
    chk("lat_no_start_yet", {31'd0, tx_start_e}, 32'd0);
    chk("lat_level1", {27'd0, lvl_e}, 32'd1);
    @(negedge clk);
    chk("lat_start", {31'd0, tx_start_e}, 32'd1);
    chk("lat_data", {24'd0, tx_data_e}, 32'h41);
    repeat (3) @(negedge clk);
    chk("edge_single_push", {27'd0, lvl_e}, 32'd0);
    wr_en_e = 1'b0;
    drain_e();
    chk("edge_one_pulse", pulses_e, 32'd1);

    // Streaming with a busy UART; the core honours cpu_stall.
    saw_stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (cpu_stall_e && (n < 200)) begin
        saw_stall = 1'b1;
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("stall_timeout", {31'd0, cpu_stall_e}, 32'd0);
      chk("stall_vs_level", {31'd0, cpu_stall_e}, {31'd0, (lvl_e >= 5'd15)});
      q_e.push_back(8'h30 + 8'(i));
      push_e(8'h30 + 8'(i));
      if (cpu_stall_e) saw_stall = 1'b1;
    end
    chk("stall_seen", {31'd0, saw_stall}, 32'd1);
    chk("stream_no_ovf", {31'd0, ovf_e}, 32'd0);
    drain_e();

    // UART stuck busy: the core ignores stall and overfills the FIFO.
    hold_e = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) q_e.push_back(8'h50 + 8'(i));
      push_e(8'h50 + 8'(i));
    end
    chk("full_level", {27'd0, lvl_e}, 32'd16);
    chk("full_ovf", {31'd0, ovf_e}, 32'd1);
    chk("full_stall", {31'd0, cpu_stall_e}, 32'd1);
    @(negedge clk);
    wr_en_e = 1'b1;
    wr_data_e = 32'h62;
    clr_e = 1'b1;
    @(negedge clk);
    chk("ovf_set_wins", {31'd0, ovf_e}, 32'd1);
    wr_en_e = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", {31'd0, ovf_e}, 32'd0);
    clr_e = 1'b0;
    chk("full_level_kept", {27'd0, lvl_e}, 32'd16);
    hold_e = 1'b0;
    drain_e();

    // LF->CRLF translation.
    q_e.push_back(8'h48);
    q_e.push_back(8'h0D);
    q_e.push_back(8'h0A);
    q_e.push_back(8'h49);
    push_e(8'h48);
    push_e(8'h0A);
    push_e(8'h49);
    drain_e();
    chk("pulses_total_e", pulses_e, 32'd41);
    chk("queue_empty_e", q_e.size(), 32'd0);

    // Level mode: push and pop in the same cycle at level 3.
    @(negedge clk);
    wr_en_l = 1'b1;
    wr_data_l = 32'hFFFF_FF11;
    @(negedge clk);
    wr_data_l = 32'h0000_0122;
    @(negedge clk);
    wr_data_l = 32'h0000_0033;
    @(negedge clk);
    wr_en_l = 1'b0;
    chk("lvl_mode_level3", {27'd0, lvl_l}, 32'd3);
    q_l.push_back(8'h11);
    q_l.push_back(8'h22);
    q_l.push_back(8'h33);
    q_l.push_back(8'h44);
    @(negedge clk);
    wr_en_l = 1'b1;
    wr_data_l = 32'h44;
    hold_l = 1'b0;
    @(negedge clk);
    wr_en_l = 1'b0;
    chk("pushpop_level3", {27'd0, lvl_l}, 32'd3);
    n = 0;
    while ((lvl_l != 0) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout_l", {27'd0, lvl_l}, 32'd0);
    repeat (30) @(negedge clk);
    chk("pulses_total_l", pulses_l, 32'd4);
    chk("queue_empty_l", q_l.size(), 32'd0);
    chk("lvl_mode_no_ovf", {31'd0, ovf_l}, 32'd0);

    // Asynchronous reset mid-transmission.
    pulses_before = pulses_e;
    q_e.push_back(8'h70);
    push_e(8'h70);
    push_e(8'h71);
    n = 0;
    while ((pulses_e == pulses_before) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("mid_start_timeout", pulses_e, pulses_before + 1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tx_start", {31'd0, tx_start_e}, 32'd0);
    chk("mid_rst_tx_data", {24'd0, tx_data_e}, 32'd0);
    chk("mid_rst_level", {27'd0, lvl_e}, 32'd0);
    chk("mid_rst_stall", {31'd0, cpu_stall_e}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf_e}, 32'd0);
    q_e.delete();
    @(negedge clk);
    rstn = 1'b1;
    pulses_before = pulses_e;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", pulses_e, pulses_before);
    chk("post_rst_level", {27'd0, lvl_e}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
